hazard_ctrl_p: RTL

- Parametrised successor to the core's stall/nop controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Produces per-stage keep (stall) and bubble (nop) controls, plus ID-stage operand forwarding selects.
- Tracks data-bus and branch-discard state sequentially.
- Sits beside the stage modules in core; consumes register-address/write-enable info from each pipe register and the bus handshakes.

---
 rtl/core_pkg.sv | 45 ++++
 rtl/raw_match.sv | 33 +++
 rtl/hazard_ctrl_p.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// +--------------------------------------------------------------------------+
// | core_pkg : shared pipeline stage, forwarding and data-bus FSM encodings  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package core_pkg;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EX  = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_ERR  = 2'd2;

    typedef struct packed {
        logic wb;
        logic mem;
        logic ex;
    } hit_t;

    // Youngest producer wins: EX holds the newest value of a register.
    function automatic logic [1:0] fwd_sel(input hit_t h, input logic wb_ok);
        logic [1:0] sel;
        sel = FWD_RF;
        if (h.ex)
            sel = FWD_EX;
        else if (h.mem)
            sel = FWD_MEM;
        else if (h.wb && wb_ok)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/raw_match.sv
// +--------------------------------------------------------------------------+
// | raw_match : compares one ID source register against EX/MEM/WB rd        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module raw_match
    import core_pkg::*;
#(
    parameter int XREG_W = 5
) (
    input  logic              used_i,
    input  logic [XREG_W-1:0] rs_i,
    input  logic [XREG_W-1:0] ex_rd_i,
    input  logic [XREG_W-1:0] mem_rd_i,
    input  logic [XREG_W-1:0] wb_rd_i,
    input  logic              ex_we_i,
    input  logic              mem_we_i,
    input  logic              wb_we_i,
    output hit_t              hit_o
);

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    logic w_live;
    assign w_live = used_i && (rs_i != '0);

    assign hit_o.ex  = w_live && ex_we_i  && (rs_i == ex_rd_i);
    assign hit_o.mem = w_live && mem_we_i && (rs_i == mem_rd_i);
    assign hit_o.wb  = w_live && wb_we_i  && (rs_i == wb_rd_i);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_p.sv
// +--------------------------------------------------------------------------+
// | hazard_ctrl_p : 5-stage stall/bubble/forward control with data-bus FSM   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl_p
    import core_pkg::*;
#(
    parameter int XREG_W      = 5,
    parameter int FORWARD_EN  = 1,
    parameter int RF_BYPASS   = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XREG_W-1:0] id_rs1,
    input  logic [XREG_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XREG_W-1:0] ex_rd,
    input  logic [XREG_W-1:0] mem_rd,
    input  logic [XREG_W-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_is_load,
    input  logic              mem_is_load,
    input  logic              mem_req,
    input  logic              dready_n,
    input  logic              dbusy,
    input  logic              iready_n,
    input  logic              branch_taken,
    output logic [4:0]        stall,
    output logic [4:0]        nop,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              bus_err,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int              CNT_W        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic            WB_NEEDS_FWD = (RF_BYPASS == 0);
    localparam logic            FWD_ON       = (FORWARD_EN != 0);

    logic [1:0]        dfsm_q, dfsm_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              discard_q, discard_d;
    logic              bus_err_q, bus_err_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    hit_t w_hit_a, w_hit_b;
    logic w_bus_pend, w_freeze, w_load_use, w_any_raw, w_raw, w_disc_fire, w_fwd_ok;

    raw_match #(.XREG_W(XREG_W)) u_match_a (
        .used_i   (id_rs1_used),
        .rs_i     (id_rs1),
        .ex_rd_i  (ex_rd),
        .mem_rd_i (mem_rd),
        .wb_rd_i  (wb_rd),
        .ex_we_i  (ex_regwrite),
        .mem_we_i (mem_regwrite),
        .wb_we_i  (wb_regwrite),
        .hit_o    (w_hit_a)
    );

    raw_match #(.XREG_W(XREG_W)) u_match_b (
        .used_i   (id_rs2_used),
        .rs_i     (id_rs2),
        .ex_rd_i  (ex_rd),
        .mem_rd_i (mem_rd),
        .wb_rd_i  (wb_rd),
        .ex_we_i  (ex_regwrite),
        .mem_we_i (mem_regwrite),
        .wb_we_i  (wb_regwrite),
        .hit_o    (w_hit_b)
    );

    // The pipeline freezes in the very cycle the bus first fails to answer.
    assign w_bus_pend = mem_req && (dready_n || dbusy);
    assign w_freeze   = (dfsm_q != D_IDLE) || w_bus_pend;

    assign w_load_use = ((w_hit_a.ex  || w_hit_b.ex)  && ex_is_load) ||
                        ((w_hit_a.mem || w_hit_b.mem) && mem_is_load);
    assign w_any_raw  = w_hit_a.ex || w_hit_b.ex || w_hit_a.mem || w_hit_b.mem ||
                        (WB_NEEDS_FWD && (w_hit_a.wb || w_hit_b.wb));
    assign w_raw      = FWD_ON ? w_load_use : w_any_raw;

    assign w_disc_fire = discard_q && !iready_n;

    always_comb begin
        stall = '0;
        nop   = '0;
        if (rst) begin
            nop = '1;
        end else if (w_freeze) begin
            stall = '1;
        end else if (branch_taken) begin
            nop[ST_EX:ST_IF] = 3'b111;
        end else begin
            if (w_raw) begin
                stall[ST_IF] = 1'b1;
                stall[ST_ID] = 1'b1;
                nop[ST_EX]   = 1'b1;
            end else if (iready_n) begin
                stall[ST_IF] = 1'b1;
                nop[ST_ID]   = 1'b1;
            end
            if (w_disc_fire)
                nop[ST_IF] = 1'b1;
        end
    end

    assign w_fwd_ok = FWD_ON && !rst && !w_raw;
    assign fwd_a    = w_fwd_ok ? fwd_sel(w_hit_a, WB_NEEDS_FWD) : FWD_RF;
    assign fwd_b    = w_fwd_ok ? fwd_sel(w_hit_b, WB_NEEDS_FWD) : FWD_RF;

    always_comb begin
        dfsm_d    = dfsm_q;
        wcnt_d    = wcnt_q;
        bus_err_d = bus_err_q;
        discard_d = discard_q;
        perf_d    = perf_q;

        case (dfsm_q)
            D_IDLE: begin
                if (w_bus_pend) begin
                    dfsm_d = D_WAIT;
                    wcnt_d = '0;
                end
            end
            D_WAIT: begin
                if (!dready_n && !dbusy) begin
                    dfsm_d = D_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    dfsm_d    = D_ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: dfsm_d = D_ERR;
        endcase

        // A taken branch with fetch still pending leaves a wrong-path word in flight.
        if (!w_freeze) begin
            if (branch_taken)
                discard_d = iready_n;
            else if (w_disc_fire)
                discard_d = 1'b0;
        end

        if ((stall != '0) && !(&perf_q))
            perf_d = perf_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dfsm_q    <= D_IDLE;
            wcnt_q    <= '0;
            discard_q <= 1'b0;
            bus_err_q <= 1'b0;
            perf_q    <= '0;
        end else begin
            dfsm_q    <= dfsm_d;
            wcnt_q    <= wcnt_d;
            discard_q <= discard_d;
            bus_err_q <= bus_err_d;
            perf_q    <= perf_d;
        end
    end

    assign bus_err      = bus_err_q;
    assign stall_cycles = perf_q;

endmodule

`default_nettype wire
